// File: rtl/synth_pkg.sv
// Shared definitions for the synthesiser control path: MIDI status codes,
// event field offsets, note range defaults and allocator FSM/event types.
package synth_pkg;

  localparam logic [3:0] STATUS_NOTE_ON  = 4'h9;
  localparam logic [3:0] STATUS_NOTE_OFF = 4'h8;

  localparam int EV_STATUS_LSB  = 20;
  localparam int EV_CHANNEL_LSB = 16;
  localparam int EV_NOTE_LSB    = 8;
  localparam int EV_VEL_LSB     = 0;

  localparam int NOTE_MIN_DEFAULT = 21;
  localparam int NOTE_MAX_DEFAULT = 116;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } alloc_state_e;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_ON   = 2'd1,
    EV_OFF  = 2'd2
  } ev_kind_e;

  typedef struct packed {
    ev_kind_e   kind;
    logic [3:0] channel;
    logic [7:0] note;
    logic [7:0] velocity;
  } alloc_event_t;

  // Out-of-range notes and unknown statuses still run a full scan but never write.
  function automatic ev_kind_e decode_kind(input logic [23:0] data,
                                           input logic [7:0]  nmin,
                                           input logic [7:0]  nmax);
    logic [3:0] status;
    logic [7:0] note;
    logic [7:0] vel;
    ev_kind_e   kind;
    status = data[EV_STATUS_LSB +: 4];
    note   = data[EV_NOTE_LSB +: 8];
    vel    = data[EV_VEL_LSB +: 8];
    if ((note < nmin) || (note > nmax)) begin
      kind = EV_NONE;
    end else if ((status == STATUS_NOTE_ON) && (vel != 8'd0)) begin
      kind = EV_ON;
    end else if ((status == STATUS_NOTE_OFF) || (status == STATUS_NOTE_ON)) begin
      kind = EV_OFF;
    end else begin
      kind = EV_NONE;
    end
    return kind;
  endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Event input and voice-bank write bus of the voice allocator.
// The master side is the MIDI event source, the slave side is the allocator.
interface voice_allocator_if #(
  parameter int NUM_VOICES = 8
);
  localparam int IDX_W = $clog2(NUM_VOICES);

  logic                  event_valid;
  logic [23:0]           event_data;
  logic                  event_ready;
  logic                  dropped;
  logic                  voice_we;
  logic [IDX_W-1:0]      voice_idx;
  logic                  voice_gate;
  logic [7:0]            voice_note;
  logic [3:0]            voice_channel;
  logic [7:0]            voice_velocity;
  logic                  voice_restart;
  logic                  stolen;
  logic [NUM_VOICES-1:0] active_mask;

  modport master (
    output event_valid, event_data,
    input  event_ready, dropped, voice_we, voice_idx, voice_gate, voice_note,
           voice_channel, voice_velocity, voice_restart, stolen, active_mask
  );

  modport slave (
    input  event_valid, event_data,
    output event_ready, dropped, voice_we, voice_idx, voice_gate, voice_note,
           voice_channel, voice_velocity, voice_restart, stolen, active_mask
  );

endinterface

// File: rtl/voice_age_tracker.sv
// Per-voice age ranks (0 = newest). Finds the oldest active voice while the
// table is scanned and re-ranks ages when a note-on is committed.
module voice_age_tracker #(
  parameter int NUM_VOICES = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_VOICES-1:0]         active_i,
  input  logic                          scan_en_i,
  input  logic [$clog2(NUM_VOICES)-1:0] scan_idx_i,
  input  logic                          update_i,
  input  logic [$clog2(NUM_VOICES)-1:0] chosen_idx_i,
  input  logic                          chosen_free_i,
  output logic [$clog2(NUM_VOICES)-1:0] oldest_idx_o
);
  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(NUM_VOICES - 1);

  logic [IDX_W-1:0] age_q [NUM_VOICES];
  logic [IDX_W-1:0] age_d [NUM_VOICES];
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [IDX_W-1:0] best_age_q, best_age_d;
  logic             best_found_q, best_found_d;
  logic             prev_found_s;
  logic [IDX_W-1:0] chosen_age_s;

  // Running max-age search; strict compare keeps the lowest index on ties.
  always_comb begin
    best_idx_d   = best_idx_q;
    best_age_d   = best_age_q;
    best_found_d = best_found_q;
    prev_found_s = best_found_q && (scan_idx_i != '0);
    if (scan_en_i) begin
      if (active_i[scan_idx_i] && (!prev_found_s || (age_q[scan_idx_i] > best_age_q))) begin
        best_idx_d   = scan_idx_i;
        best_age_d   = age_q[scan_idx_i];
        best_found_d = 1'b1;
      end else begin
        best_found_d = prev_found_s;
      end
    end else begin
      best_found_d = best_found_q;
    end
    oldest_idx_o = best_idx_d;
  end

  // Chosen voice becomes newest; younger active voices age by one (saturating).
  always_comb begin
    chosen_age_s = age_q[chosen_idx_i];
    for (int v = 0; v < NUM_VOICES; v++) begin
      age_d[v] = age_q[v];
      if (update_i) begin
        if (IDX_W'(v) == chosen_idx_i) begin
          age_d[v] = '0;
        end else if (active_i[v] && (chosen_free_i || (age_q[v] < chosen_age_s))
                     && (age_q[v] != AGE_MAX)) begin
          age_d[v] = age_q[v] + 1'b1;
        end else begin
          age_d[v] = age_q[v];
        end
      end else begin
        age_d[v] = age_q[v];
      end
    end
  end

  // Age table and scan accumulator registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        age_q[v] <= '0;
      end
      best_idx_q   <= '0;
      best_age_q   <= '0;
      best_found_q <= 1'b0;
    end else begin
      age_q        <= age_d;
      best_idx_q   <= best_idx_d;
      best_age_q   <= best_age_d;
      best_found_q <= best_found_d;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Voice scheduler: decodes MIDI events, scans the occupancy table one entry per
// cycle, and issues a single voice-bank write with fixed latency.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int NOTE_MIN   = NOTE_MIN_DEFAULT,
  parameter int NOTE_MAX   = NOTE_MAX_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  voice_allocator_if.slave   alloc_bus
);
  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  alloc_state_e          state_q, state_d;
  logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;
  alloc_event_t          ev_q, ev_d;

  logic [NUM_VOICES-1:0] active_q, active_d;
  logic [3:0]            chan_q [NUM_VOICES];
  logic [3:0]            chan_d [NUM_VOICES];
  logic [7:0]            note_q [NUM_VOICES];
  logic [7:0]            note_d [NUM_VOICES];

  logic                  match_found_q, match_found_d;
  logic [IDX_W-1:0]      match_idx_q, match_idx_d;
  logic                  free_found_q, free_found_d;
  logic [IDX_W-1:0]      free_idx_q, free_idx_d;

  logic                  voice_we_q, voice_we_d;
  logic [IDX_W-1:0]      voice_idx_q, voice_idx_d;
  logic                  commit_on_q, commit_on_d;
  logic                  commit_free_q, commit_free_d;
  logic                  voice_gate_q, voice_gate_d;
  logic [7:0]            voice_note_q, voice_note_d;
  logic [3:0]            voice_channel_q, voice_channel_d;
  logic [7:0]            voice_velocity_q, voice_velocity_d;
  logic                  voice_restart_q, voice_restart_d;
  logic                  stolen_q, stolen_d;
  logic                  dropped_q, dropped_d;

  logic                  accept_s, scan_s, scan_last_s, first_s, hit_s;
  logic                  match_prev_s, free_prev_s, age_update_s;
  logic [IDX_W-1:0]      oldest_idx_s;

  assign accept_s     = alloc_bus.event_valid && (state_q == ST_IDLE);
  assign scan_s       = (state_q == ST_SCAN);
  assign scan_last_s  = scan_s && (scan_idx_q == LAST_IDX);
  assign age_update_s = (state_q == ST_COMMIT) && voice_we_q && commit_on_q;

  voice_age_tracker #(.NUM_VOICES(NUM_VOICES)) u_age (
    .clock         (clock),
    .reset         (reset),
    .active_i      (active_q),
    .scan_en_i     (scan_s),
    .scan_idx_i    (scan_idx_q),
    .update_i      (age_update_s),
    .chosen_idx_i  (voice_idx_q),
    .chosen_free_i (commit_free_q),
    .oldest_idx_o  (oldest_idx_s)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = accept_s ? ST_SCAN : ST_IDLE;
      ST_SCAN:   state_d = (scan_idx_q == LAST_IDX) ? ST_COMMIT : ST_SCAN;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM/bus outputs; everything but event_ready comes straight from registers.
  always_comb begin
    alloc_bus.event_ready    = (state_q == ST_IDLE);
    alloc_bus.dropped        = dropped_q;
    alloc_bus.voice_we       = voice_we_q;
    alloc_bus.voice_idx      = voice_idx_q;
    alloc_bus.voice_gate     = voice_gate_q;
    alloc_bus.voice_note     = voice_note_q;
    alloc_bus.voice_channel  = voice_channel_q;
    alloc_bus.voice_velocity = voice_velocity_q;
    alloc_bus.voice_restart  = voice_restart_q;
    alloc_bus.stolen         = stolen_q;
    alloc_bus.active_mask    = active_q;
  end

  // Event capture, scan comparators and the one-shot voice decision.
  always_comb begin
    ev_d = ev_q;
    if (accept_s) begin
      ev_d.kind     = decode_kind(alloc_bus.event_data, 8'(NOTE_MIN), 8'(NOTE_MAX));
      ev_d.channel  = alloc_bus.event_data[EV_CHANNEL_LSB +: 4];
      ev_d.note     = alloc_bus.event_data[EV_NOTE_LSB +: 8];
      ev_d.velocity = alloc_bus.event_data[EV_VEL_LSB +: 8];
    end else begin
      ev_d = ev_q;
    end

    scan_idx_d   = scan_s ? (scan_idx_q + 1'b1) : '0;
    first_s      = (scan_idx_q == '0);
    hit_s        = active_q[scan_idx_q] && (chan_q[scan_idx_q] == ev_q.channel)
                   && (note_q[scan_idx_q] == ev_q.note);
    match_prev_s = match_found_q && !first_s;
    free_prev_s  = free_found_q && !first_s;
    if (scan_s) begin
      match_found_d = match_prev_s || hit_s;
      match_idx_d   = (!match_prev_s && hit_s) ? scan_idx_q : match_idx_q;
      free_found_d  = free_prev_s || !active_q[scan_idx_q];
      free_idx_d    = (!free_prev_s && !active_q[scan_idx_q]) ? scan_idx_q : free_idx_q;
    end else begin
      match_found_d = match_found_q;
      match_idx_d   = match_idx_q;
      free_found_d  = free_found_q;
      free_idx_d    = free_idx_q;
    end

    voice_we_d       = 1'b0;
    voice_idx_d      = voice_idx_q;
    commit_on_d      = 1'b0;
    commit_free_d    = 1'b0;
    stolen_d         = 1'b0;
    voice_gate_d     = voice_gate_q;
    voice_note_d     = voice_note_q;
    voice_channel_d  = voice_channel_q;
    voice_velocity_d = voice_velocity_q;
    voice_restart_d  = voice_restart_q;
    if (scan_last_s) begin
      case (ev_q.kind)
        EV_ON: begin
          voice_we_d       = 1'b1;
          commit_on_d      = 1'b1;
          voice_gate_d     = 1'b1;
          voice_restart_d  = 1'b1;
          voice_note_d     = ev_q.note;
          voice_channel_d  = ev_q.channel;
          voice_velocity_d = ev_q.velocity;
          if (match_found_d) begin
            voice_idx_d = match_idx_d;
          end else if (free_found_d) begin
            voice_idx_d   = free_idx_d;
            commit_free_d = 1'b1;
          end else begin
            voice_idx_d = oldest_idx_s;
            stolen_d    = 1'b1;
          end
        end
        EV_OFF: begin
          if (match_found_d) begin
            voice_we_d       = 1'b1;
            voice_idx_d      = match_idx_d;
            voice_gate_d     = 1'b0;
            voice_restart_d  = 1'b0;
            voice_note_d     = ev_q.note;
            voice_channel_d  = ev_q.channel;
            voice_velocity_d = 8'd0;
          end else begin
            voice_we_d = 1'b0;
          end
        end
        default: voice_we_d = 1'b0;
      endcase
    end else begin
      voice_we_d = 1'b0;
    end

    // Only flag drops that land while still busy, so the pulse never shows in IDLE.
    dropped_d = alloc_bus.event_valid && scan_s;
  end

  // Occupancy table changes only in COMMIT, using the decision latched at scan end.
  always_comb begin
    active_d = active_q;
    chan_d   = chan_q;
    note_d   = note_q;
    if ((state_q == ST_COMMIT) && voice_we_q) begin
      if (commit_on_q) begin
        active_d[voice_idx_q] = 1'b1;
        chan_d[voice_idx_q]   = ev_q.channel;
        note_d[voice_idx_q]   = ev_q.note;
      end else begin
        active_d[voice_idx_q] = 1'b0;
      end
    end else begin
      active_d = active_q;
    end
  end

  // Datapath, table and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      scan_idx_q       <= '0;
      ev_q             <= '0;
      active_q         <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        chan_q[v] <= 4'd0;
        note_q[v] <= 8'd0;
      end
      match_found_q    <= 1'b0;
      match_idx_q      <= '0;
      free_found_q     <= 1'b0;
      free_idx_q       <= '0;
      voice_we_q       <= 1'b0;
      voice_idx_q      <= '0;
      commit_on_q      <= 1'b0;
      commit_free_q    <= 1'b0;
      voice_gate_q     <= 1'b0;
      voice_note_q     <= 8'd0;
      voice_channel_q  <= 4'd0;
      voice_velocity_q <= 8'd0;
      voice_restart_q  <= 1'b0;
      stolen_q         <= 1'b0;
      dropped_q        <= 1'b0;
    end else begin
      scan_idx_q       <= scan_idx_d;
      ev_q             <= ev_d;
      active_q         <= active_d;
      chan_q           <= chan_d;
      note_q           <= note_d;
      match_found_q    <= match_found_d;
      match_idx_q      <= match_idx_d;
      free_found_q     <= free_found_d;
      free_idx_q       <= free_idx_d;
      voice_we_q       <= voice_we_d;
      voice_idx_q      <= voice_idx_d;
      commit_on_q      <= commit_on_d;
      commit_free_q    <= commit_free_d;
      voice_gate_q     <= voice_gate_d;
      voice_note_q     <= voice_note_d;
      voice_channel_q  <= voice_channel_d;
      voice_velocity_q <= voice_velocity_d;
      voice_restart_q  <= voice_restart_d;
      stolen_q         <= stolen_d;
      dropped_q        <= dropped_d;
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed vector bench for voice_allocator with NUM_VOICES = 8.
module tb_voice_allocator;

  typedef struct {
    logic [23:0] data;
    logic        we;
    logic [2:0]  idx;
    logic        gate;
    logic [7:0]  note;
    logic [3:0]  ch;
    logic [7:0]  vel;
    logic        restart;
    logic        stolen;
    logic [7:0]  mask;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   we_seen = 0;
  int   we_expected = 0;
  int   drop_seen = 0;
  vec_t vecs[14];
  vec_t v;

  voice_allocator_if #(.NUM_VOICES(8)) bus ();

  voice_allocator #(.NUM_VOICES(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .alloc_bus (bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (bus.voice_we === 1'b1) we_seen++;
    if (bus.dropped === 1'b1) drop_seen++;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Event offered at negedge N0; write expected at N9, mask/ready at N10.
  task automatic run_vector(input vec_t vv, input string tag);
    @(negedge clock);
    bus.event_valid = 1'b1;
    bus.event_data  = vv.data;
    @(negedge clock);
    bus.event_valid = 1'b0;
    repeat (8) @(negedge clock);
    check({tag, ".we"}, 32'(bus.voice_we), 32'(vv.we));
    if (vv.we) begin
      we_expected++;
      check({tag, ".idx"}, 32'(bus.voice_idx), 32'(vv.idx));
      check({tag, ".gate"}, 32'(bus.voice_gate), 32'(vv.gate));
      check({tag, ".note"}, 32'(bus.voice_note), 32'(vv.note));
      check({tag, ".ch"}, 32'(bus.voice_channel), 32'(vv.ch));
      check({tag, ".vel"}, 32'(bus.voice_velocity), 32'(vv.vel));
      check({tag, ".restart"}, 32'(bus.voice_restart), 32'(vv.restart));
      check({tag, ".stolen"}, 32'(bus.stolen), 32'(vv.stolen));
    end
    @(negedge clock);
    check({tag, ".mask"}, 32'(bus.active_mask), 32'(vv.mask));
    check({tag, ".ready"}, 32'(bus.event_ready), 32'd1);
  endtask

  initial begin
    bus.event_valid = 1'b0;
    bus.event_data  = 24'h000000;

    vecs[0]  = '{24'h903C64, 1'b1, 3'd0, 1'b1, 8'd60, 4'd0, 8'd100, 1'b1, 1'b0, 8'h01};
    vecs[1]  = '{24'h903C5A, 1'b1, 3'd0, 1'b1, 8'd60, 4'd0, 8'd90,  1'b1, 1'b0, 8'h01};
    vecs[2]  = '{24'h903E50, 1'b1, 3'd1, 1'b1, 8'd62, 4'd0, 8'd80,  1'b1, 1'b0, 8'h03};
    vecs[3]  = '{24'h803C40, 1'b1, 3'd0, 1'b0, 8'd60, 4'd0, 8'd0,   1'b0, 1'b0, 8'h02};
    vecs[4]  = '{24'h903C64, 1'b1, 3'd0, 1'b1, 8'd60, 4'd0, 8'd100, 1'b1, 1'b0, 8'h03};
    vecs[5]  = '{24'h903C00, 1'b1, 3'd0, 1'b0, 8'd60, 4'd0, 8'd0,   1'b0, 1'b0, 8'h02};
    vecs[6]  = '{24'h806340, 1'b0, 3'd0, 1'b0, 8'd0,  4'd0, 8'd0,   1'b0, 1'b0, 8'h02};
    vecs[7]  = '{24'h900A64, 1'b0, 3'd0, 1'b0, 8'd0,  4'd0, 8'd0,   1'b0, 1'b0, 8'h02};
    vecs[8]  = '{24'h907564, 1'b0, 3'd0, 1'b0, 8'd0,  4'd0, 8'd0,   1'b0, 1'b0, 8'h02};
    vecs[9]  = '{24'hB03C64, 1'b0, 3'd0, 1'b0, 8'd0,  4'd0, 8'd0,   1'b0, 1'b0, 8'h02};
    vecs[10] = '{24'h913E50, 1'b1, 3'd0, 1'b1, 8'd62, 4'd1, 8'd80,  1'b1, 1'b0, 8'h03};
    vecs[11] = '{24'h803E00, 1'b1, 3'd1, 1'b0, 8'd62, 4'd0, 8'd0,   1'b0, 1'b0, 8'h01};
    vecs[12] = '{24'h901564, 1'b1, 3'd1, 1'b1, 8'd21, 4'd0, 8'd100, 1'b1, 1'b0, 8'h03};
    vecs[13] = '{24'h907464, 1'b1, 3'd2, 1'b1, 8'd116, 4'd0, 8'd100, 1'b1, 1'b0, 8'h07};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst.ready", 32'(bus.event_ready), 32'd1);
    check("rst.we", 32'(bus.voice_we), 32'd0);
    check("rst.mask", 32'(bus.active_mask), 32'd0);
    check("rst.dropped", 32'(bus.dropped), 32'd0);
    check("rst.idx", 32'(bus.voice_idx), 32'd0);

    for (int i = 0; i < 14; i++) begin
      run_vector(vecs[i], $sformatf("vec%0d", i));
    end

    // Fill all eight voices, then two more note-ons steal the two oldest.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      v = '{{4'h9, 4'h0, 8'(60 + i), 8'd100}, 1'b1, 3'(i), 1'b1, 8'(60 + i), 4'd0,
            8'd100, 1'b1, 1'b0, 8'((16'd1 << (i + 1)) - 16'd1)};
      run_vector(v, $sformatf("fill%0d", i));
    end
    v = '{24'h904664, 1'b1, 3'd0, 1'b1, 8'd70, 4'd0, 8'd100, 1'b1, 1'b1, 8'hFF};
    run_vector(v, "steal70");
    v = '{24'h904764, 1'b1, 3'd1, 1'b1, 8'd71, 4'd0, 8'd100, 1'b1, 1'b1, 8'hFF};
    run_vector(v, "steal71");

    // Second event offered mid-scan must be dropped without a write.
    do_reset();
    @(negedge clock);
    bus.event_valid = 1'b1;
    bus.event_data  = 24'h903C64;
    @(negedge clock);
    bus.event_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("drop.ready_busy", 32'(bus.event_ready), 32'd0);
    bus.event_valid = 1'b1;
    bus.event_data  = 24'h903E64;
    @(negedge clock);
    bus.event_valid = 1'b0;
    check("drop.pulse", 32'(bus.dropped), 32'd1);
    repeat (5) @(negedge clock);
    check("drop.we", 32'(bus.voice_we), 32'd1);
    check("drop.note", 32'(bus.voice_note), 32'd60);
    we_expected++;
    @(negedge clock);
    check("drop.mask", 32'(bus.active_mask), 32'h01);
    repeat (12) @(negedge clock);
    check("drop.count", 32'(drop_seen), 32'd1);

    // Reset at T+4 discards the pending note-on.
    @(negedge clock);
    bus.event_valid = 1'b1;
    bus.event_data  = 24'h903E64;
    @(negedge clock);
    bus.event_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst.mask", 32'(bus.active_mask), 32'h00);
    @(negedge clock);
    check("midrst.ready", 32'(bus.event_ready), 32'd1);
    repeat (12) @(negedge clock);
    check("midrst.mask_late", 32'(bus.active_mask), 32'h00);

    check("total.we_count", 32'(we_seen), 32'(we_expected));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
